// File: rtl/usb_hid_pkg.sv
// Shared definitions for the USB HID report controller.
// Holds the register word map, CTRL bit positions, the byte offsets of the
// fields inside the staging words, the per-device connection state type and
// the sign-extension helper used by the mouse accumulators.
package usb_hid_pkg;

  // Register word addresses (cpu_ad[5:2])
  localparam logic [3:0] ADDR_KBD0  = 4'd0;
  localparam logic [3:0] ADDR_KBD1  = 4'd1;
  localparam logic [3:0] ADDR_MOUSE = 4'd2;
  localparam logic [3:0] ADDR_CTRL  = 4'd3;
  localparam logic [3:0] ADDR_MX    = 4'd4;
  localparam logic [3:0] ADDR_MY    = 4'd5;
  localparam logic [3:0] ADDR_WHEEL = 4'd6;

  // CTRL write bits
  localparam int unsigned CTRL_KBD_COMMIT   = 32'd0;
  localparam int unsigned CTRL_MOUSE_COMMIT = 32'd1;
  localparam int unsigned CTRL_KBD_DISC     = 32'd4;
  localparam int unsigned CTRL_MOUSE_DISC   = 32'd5;
  localparam int unsigned CTRL_MOUSE_ZERO   = 32'd8;

  // Byte offsets inside the staging words
  localparam int unsigned KBD_MOD_LSB   = 32'd0;
  localparam int unsigned KBD_KEY0_LSB  = 32'd8;
  localparam int unsigned MOUSE_BTN_LSB = 32'd0;
  localparam int unsigned MOUSE_DX_LSB  = 32'd8;
  localparam int unsigned MOUSE_DY_LSB  = 32'd16;
  localparam int unsigned MOUSE_WHL_LSB = 32'd24;

  // KBD1 only holds three key bytes; the top byte always reads back as zero
  localparam logic [31:0] KBD1_MASK = 32'h00FF_FFFF;

  typedef enum logic [0:0] {
    ST_DISCONNECTED = 1'b0,
    ST_CONNECTED    = 1'b1
  } conn_state_e;

  // Extract one byte from a 32-bit word at the given bit offset
  function automatic logic [7:0] byte_at(input logic [31:0] w, input int unsigned lsb);
    return w[lsb +: 8];
  endfunction

  // Sign-extend an 8-bit HID delta to the 32-bit accumulator width
  function automatic logic [31:0] sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

endpackage

// File: rtl/usb_hid_report_ctrl_watchdog.sv
// hid_conn_watchdog: connection state machine plus millisecond inactivity
// counter for one HID device.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   tick_i         1 ms tick from the shared prescaler
//   commit_i       firmware commit strobe for this device
//   disc_i         firmware disconnect strobe for this device
//   connected_o    device present (state register)
//   accept_o       commit takes effect this cycle (disconnect has priority)
//   drop_o         disconnect action this cycle (firmware or timeout)
module hid_conn_watchdog
  import usb_hid_pkg::*;
#(
  parameter int CONN_TIMEOUT_MS = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic commit_i,
  input  logic disc_i,
  output logic connected_o,
  output logic accept_o,
  output logic drop_o
);

  localparam logic        WD_EN   = (CONN_TIMEOUT_MS > 0) ? 1'b1 : 1'b0;
  // Timeout fires on the tick that would move the counter onto the limit
  localparam logic [31:0] MS_LAST = (CONN_TIMEOUT_MS > 0) ? 32'(CONN_TIMEOUT_MS - 1) : 32'd0;
  localparam logic [31:0] MS_MAX  = 32'hFFFF_FFFF;

  conn_state_e state_q, state_d;
  logic [31:0] ms_q, ms_d;
  logic        timeout_s;

  assign connected_o = (state_q == ST_CONNECTED);
  assign timeout_s   = WD_EN & connected_o & tick_i & (ms_q >= MS_LAST);
  assign accept_o    = commit_i & ~disc_i;
  // A commit landing on the timeout cycle keeps the device alive
  assign drop_o      = disc_i | (timeout_s & ~commit_i);

  // Connection state and ms counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_DISCONNECTED;
      ms_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
    end
  end

  // Next-state logic for the connection FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISCONNECTED: begin
        if (accept_o) state_d = ST_CONNECTED;
        else          state_d = ST_DISCONNECTED;
      end
      ST_CONNECTED: begin
        if (drop_o) state_d = ST_DISCONNECTED;
        else        state_d = ST_CONNECTED;
      end
      default: state_d = ST_DISCONNECTED;
    endcase
  end

  // Saturating ms counter, cleared on any commit or disconnect
  always_comb begin
    ms_d = ms_q;
    if (accept_o || drop_o) begin
      ms_d = 32'd0;
    end else if (connected_o && tick_i && (ms_q != MS_MAX)) begin
      ms_d = ms_q + 32'd1;
    end else begin
      ms_d = ms_q;
    end
  end

endmodule

// File: rtl/usb_hid_report_ctrl.sv
// usb_hid_report_ctrl: CPU-bus slave publishing keyboard and mouse HID state.
// Firmware writes staging words, then commits them via CTRL so the published
// report changes on one edge. Mouse deltas accumulate into 32-bit wrapping
// positions. Each device has a watchdog that disconnects it when commits stop.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   m_sel/m_addr/m_rd/m_wr/m_data_i/m_data_o  CPU bus (read data combinational)
//   keyboard_connected, keyboard_modifiers, keyboard_keycodes  keyboard report
//   mouse_connected, mouse_buttons, mouse_x/y/wheel            mouse report
//   kbd_update_o, mouse_update_o  one-cycle pulse after an accepted commit
module usb_hid_report_ctrl
  import usb_hid_pkg::*;
#(
  parameter int TICK_DIV        = 48000,
  parameter int CONN_TIMEOUT_MS = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m_sel,
  input  logic [3:0]  m_addr,
  input  logic [31:0] m_data_i,
  output logic [31:0] m_data_o,
  input  logic        m_rd,
  input  logic        m_wr,
  output logic        keyboard_connected,
  output logic        mouse_connected,
  output logic [7:0]  keyboard_modifiers,
  output logic [47:0] keyboard_keycodes,
  output logic [7:0]  mouse_buttons,
  output logic [31:0] mouse_x,
  output logic [31:0] mouse_y,
  output logic [31:0] mouse_wheel,
  output logic        kbd_update_o,
  output logic        mouse_update_o
);

  localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);

  logic             wr_s, ctrl_wr_s, tick_s;
  logic             kbd_commit_s, kbd_disc_s, mouse_commit_s, mouse_disc_s, mouse_zero_s;
  logic             kbd_accept_s, kbd_drop_s, mouse_accept_s, mouse_drop_s;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [31:0]      kbd0_q, kbd0_d, kbd1_q, kbd1_d, mstage_q, mstage_d;
  logic [7:0]       kmod_q, kmod_d, mbtn_q, mbtn_d;
  logic [47:0]      kkeys_q, kkeys_d;
  logic [31:0]      mx_q, mx_d, my_q, my_d, mw_q, mw_d;
  logic [31:0]      mx_base_s, my_base_s, mw_base_s, rd_s;
  logic             kupd_q, mupd_q;

  assign wr_s           = m_sel & m_wr;
  assign ctrl_wr_s      = wr_s & (m_addr == ADDR_CTRL);
  assign kbd_commit_s   = ctrl_wr_s & m_data_i[CTRL_KBD_COMMIT];
  assign mouse_commit_s = ctrl_wr_s & m_data_i[CTRL_MOUSE_COMMIT];
  assign kbd_disc_s     = ctrl_wr_s & m_data_i[CTRL_KBD_DISC];
  assign mouse_disc_s   = ctrl_wr_s & m_data_i[CTRL_MOUSE_DISC];
  assign mouse_zero_s   = ctrl_wr_s & m_data_i[CTRL_MOUSE_ZERO];
  assign tick_s         = (pre_q == PRE_LAST);

  hid_conn_watchdog #(.CONN_TIMEOUT_MS(CONN_TIMEOUT_MS)) u_kbd_wd (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .tick_i      (tick_s),
    .commit_i    (kbd_commit_s),
    .disc_i      (kbd_disc_s),
    .connected_o (keyboard_connected),
    .accept_o    (kbd_accept_s),
    .drop_o      (kbd_drop_s)
  );

  hid_conn_watchdog #(.CONN_TIMEOUT_MS(CONN_TIMEOUT_MS)) u_mouse_wd (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .tick_i      (tick_s),
    .commit_i    (mouse_commit_s),
    .disc_i      (mouse_disc_s),
    .connected_o (mouse_connected),
    .accept_o    (mouse_accept_s),
    .drop_o      (mouse_drop_s)
  );

  // Free-running 1 ms prescaler
  always_comb begin
    if (tick_s) pre_d = PRE_ZERO;
    else        pre_d = pre_q + PRE_ONE;
  end

  // Staging registers: plain bus writes, never touched by commit/disconnect
  always_comb begin
    kbd0_d   = kbd0_q;
    kbd1_d   = kbd1_q;
    mstage_d = mstage_q;
    if (wr_s) begin
      case (m_addr)
        ADDR_KBD0:  kbd0_d   = m_data_i;
        ADDR_KBD1:  kbd1_d   = m_data_i & KBD1_MASK;
        ADDR_MOUSE: mstage_d = m_data_i;
        default:    kbd0_d   = kbd0_q;
      endcase
    end else begin
      kbd0_d = kbd0_q;
    end
  end

  // Keyboard report: whole report copied on one edge; disconnect wins
  always_comb begin
    kmod_d  = kmod_q;
    kkeys_d = kkeys_q;
    if (kbd_drop_s) begin
      kmod_d  = 8'h00;
      kkeys_d = 48'h0;
    end else if (kbd_accept_s) begin
      kmod_d  = byte_at(kbd0_q, KBD_MOD_LSB);
      kkeys_d = {kbd1_q[23:0], kbd0_q[31:KBD_KEY0_LSB]};
    end else begin
      kmod_d  = kmod_q;
      kkeys_d = kkeys_q;
    end
  end

  // Mouse report: zero is applied before the delta; disconnect holds positions
  always_comb begin
    mbtn_d    = mbtn_q;
    mx_base_s = mouse_zero_s ? 32'h0 : mx_q;
    my_base_s = mouse_zero_s ? 32'h0 : my_q;
    mw_base_s = mouse_zero_s ? 32'h0 : mw_q;
    mx_d      = mx_base_s;
    my_d      = my_base_s;
    mw_d      = mw_base_s;
    if (mouse_drop_s) begin
      mbtn_d = 8'h00;
    end else if (mouse_accept_s) begin
      mbtn_d = byte_at(mstage_q, MOUSE_BTN_LSB);
      mx_d   = mx_base_s + sext8(byte_at(mstage_q, MOUSE_DX_LSB));
      my_d   = my_base_s + sext8(byte_at(mstage_q, MOUSE_DY_LSB));
      mw_d   = mw_base_s + sext8(byte_at(mstage_q, MOUSE_WHL_LSB));
    end else begin
      mbtn_d = mbtn_q;
    end
  end

  // All datapath registers of the block
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q    <= PRE_ZERO;
      kbd0_q   <= 32'h0;
      kbd1_q   <= 32'h0;
      mstage_q <= 32'h0;
      kmod_q   <= 8'h00;
      kkeys_q  <= 48'h0;
      mbtn_q   <= 8'h00;
      mx_q     <= 32'h0;
      my_q     <= 32'h0;
      mw_q     <= 32'h0;
      kupd_q   <= 1'b0;
      mupd_q   <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      kbd0_q   <= kbd0_d;
      kbd1_q   <= kbd1_d;
      mstage_q <= mstage_d;
      kmod_q   <= kmod_d;
      kkeys_q  <= kkeys_d;
      mbtn_q   <= mbtn_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      mw_q     <= mw_d;
      kupd_q   <= kbd_accept_s;
      mupd_q   <= mouse_accept_s;
    end
  end

  // Read mux; unmapped words read as zero
  always_comb begin
    rd_s = 32'h0;
    case (m_addr)
      ADDR_KBD0:  rd_s = kbd0_q;
      ADDR_KBD1:  rd_s = kbd1_q;
      ADDR_MOUSE: rd_s = mstage_q;
      ADDR_CTRL:  rd_s = {30'd0, mouse_connected, keyboard_connected};
      ADDR_MX:    rd_s = mx_q;
      ADDR_MY:    rd_s = my_q;
      ADDR_WHEEL: rd_s = mw_q;
      default:    rd_s = 32'h0;
    endcase
  end

  assign m_data_o           = (m_sel & m_rd) ? rd_s : 32'h0;
  assign keyboard_modifiers = kmod_q;
  assign keyboard_keycodes  = kkeys_q;
  assign mouse_buttons      = mbtn_q;
  assign mouse_x            = mx_q;
  assign mouse_y            = my_q;
  assign mouse_wheel        = mw_q;
  assign kbd_update_o       = kupd_q;
  assign mouse_update_o     = mupd_q;

endmodule

// File: tb/tb_usb_hid_report_ctrl.sv
// Self-checking bench for usb_hid_report_ctrl (TICK_DIV=4, CONN_TIMEOUT_MS=3).
// Expected reports are queued when a commit is issued; a monitor pops and
// compares them whenever the DUT raises an update pulse.
module tb_usb_hid_report_ctrl;

  logic        clk, rst;
  logic        m_sel, m_rd, m_wr;
  logic [3:0]  m_addr;
  logic [31:0] m_data_i, m_data_o;
  logic        keyboard_connected, mouse_connected;
  logic [7:0]  keyboard_modifiers, mouse_buttons;
  logic [47:0] keyboard_keycodes;
  logic [31:0] mouse_x, mouse_y, mouse_wheel;
  logic        kbd_update_o, mouse_update_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  typedef struct { logic [7:0] mods; logic [47:0] keys; } kbd_exp_t;
  typedef struct { logic [7:0] btn; logic [31:0] x, y, w; } mouse_exp_t;
  kbd_exp_t   kbd_q[$];
  mouse_exp_t mouse_q[$];
  kbd_exp_t   ke;
  mouse_exp_t me;

  usb_hid_report_ctrl #(.TICK_DIV(4), .CONN_TIMEOUT_MS(3)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .m_sel              (m_sel),
    .m_addr             (m_addr),
    .m_data_i           (m_data_i),
    .m_data_o           (m_data_o),
    .m_rd               (m_rd),
    .m_wr               (m_wr),
    .keyboard_connected (keyboard_connected),
    .mouse_connected    (mouse_connected),
    .keyboard_modifiers (keyboard_modifiers),
    .keyboard_keycodes  (keyboard_keycodes),
    .mouse_buttons      (mouse_buttons),
    .mouse_x            (mouse_x),
    .mouse_y            (mouse_y),
    .mouse_wheel        (mouse_wheel),
    .kbd_update_o       (kbd_update_o),
    .mouse_update_o     (mouse_update_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges seen since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (kbd_update_o) begin
        if (kbd_q.size() == 0) begin
          check("kbd_update_spurious", 64'(kbd_update_o), 64'd0);
        end else begin
          ke = kbd_q.pop_front();
          check("kbd_mods", 64'(keyboard_modifiers), 64'(ke.mods));
          check("kbd_keys", 64'(keyboard_keycodes), 64'(ke.keys));
          check("kbd_conn", 64'(keyboard_connected), 64'd1);
        end
      end
      if (mouse_update_o) begin
        if (mouse_q.size() == 0) begin
          check("mouse_update_spurious", 64'(mouse_update_o), 64'd0);
        end else begin
          me = mouse_q.pop_front();
          check("mouse_btn", 64'(mouse_buttons), 64'(me.btn));
          check("mouse_x", 64'(mouse_x), 64'(me.x));
          check("mouse_y", 64'(mouse_y), 64'(me.y));
          check("mouse_wheel", 64'(mouse_wheel), 64'(me.w));
          check("mouse_conn", 64'(mouse_connected), 64'd1);
        end
      end
    end
  end

  task automatic push_kbd(input logic [7:0] m, input logic [47:0] k);
    kbd_exp_t e;
    e.mods = m; e.keys = k;
    kbd_q.push_back(e);
  endtask

  task automatic push_mouse(input logic [7:0] b, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] w);
    mouse_exp_t e;
    e.btn = b; e.x = x; e.y = y; e.w = w;
    mouse_q.push_back(e);
  endtask

  // Drive a write now (caller is at a negedge); sampled on the next posedge
  task automatic bus_wr_now(input logic [3:0] a, input logic [31:0] d);
    m_sel = 1'b1; m_wr = 1'b1; m_addr = a; m_data_i = d;
    @(posedge clk);
    #1;
    m_sel = 1'b0; m_wr = 1'b0;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_wr_now(a, d);
  endtask

  task automatic bus_rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk);
    m_sel = 1'b1; m_rd = 1'b1; m_addr = a;
    #1;
    check(name, 64'(m_data_o), 64'(exp));
    m_sel = 1'b0; m_rd = 1'b0;
  endtask

  // Edge at which a device committed at edge c times out (3rd tick after c)
  function automatic int fall_edge(input int c);
    int e, t;
    e = c; t = 0;
    while (t < 3) begin
      e++;
      if (e % 4 == 0) t++;
    end
    return e;
  endfunction

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 200 && cyc != n; i++) @(negedge clk);
    check("wait_cyc_reached", 64'(cyc), 64'(n));
  endtask

  int c, f;

  initial begin
    rst = 1'b1; m_sel = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_addr = 4'd0; m_data_i = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    // Reset state
    check("rst_kconn", 64'(keyboard_connected), 64'd0);
    check("rst_mconn", 64'(mouse_connected), 64'd0);
    check("rst_mods", 64'(keyboard_modifiers), 64'd0);
    check("rst_keys", 64'(keyboard_keycodes), 64'd0);
    check("rst_mx", 64'(mouse_x), 64'd0);
    check("rst_upd", 64'({kbd_update_o, mouse_update_o}), 64'd0);
    bus_rd_chk("rst_rd_kbd0", 4'd0, 32'h0);

    // Test 1: keyboard commit
    bus_wr(4'd0, 32'h06050402);
    bus_wr(4'd1, 32'h00090807);
    push_kbd(8'h02, 48'h090807060504);
    bus_wr(4'd3, 32'h1);
    check("t1_mods_same_edge", 64'(keyboard_modifiers), 64'h02);
    check("t1_pulse_hi", 64'(kbd_update_o), 64'd1);
    @(posedge clk); #1;
    check("t1_pulse_lo", 64'(kbd_update_o), 64'd0);

    // Test 2: mouse accumulation
    bus_wr(4'd2, 32'h00FE0301);
    push_mouse(8'h01, 32'd3, 32'hFFFFFFFE, 32'd0);
    bus_wr(4'd3, 32'h2);
    push_mouse(8'h01, 32'd6, 32'hFFFFFFFC, 32'd0);
    bus_wr(4'd3, 32'h2);
    bus_wr(4'd2, 32'h01000000);
    push_mouse(8'h00, 32'd6, 32'hFFFFFFFC, 32'd1);
    bus_wr(4'd3, 32'h2);
    bus_rd_chk("t2_rd_x", 4'd4, 32'd6);
    bus_rd_chk("t2_rd_y", 4'd5, 32'hFFFFFFFC);
    bus_rd_chk("t2_rd_wheel", 4'd6, 32'd1);

    // Test 3: 32-bit wrap and zero-then-add
    bus_wr(4'd2, 32'h0000FF00);
    push_mouse(8'h00, 32'hFFFFFFFF, 32'd0, 32'd0);
    bus_wr(4'd3, 32'h102);
    bus_wr(4'd2, 32'h00000100);
    push_mouse(8'h00, 32'd0, 32'd0, 32'd0);
    bus_wr(4'd3, 32'h2);
    push_mouse(8'h00, 32'd1, 32'd0, 32'd0);
    bus_wr(4'd3, 32'h2);
    bus_wr(4'd2, 32'h00000500);
    push_mouse(8'h00, 32'd5, 32'd0, 32'd0);
    bus_wr(4'd3, 32'h102);

    // Mouse disconnect overrides commit and holds positions; zero alone clears
    bus_wr(4'd2, 32'h02FF0183);
    push_mouse(8'h83, 32'd6, 32'hFFFFFFFF, 32'd2);
    bus_wr(4'd3, 32'h2);
    bus_wr(4'd3, 32'h22);
    check("md_conn", 64'(mouse_connected), 64'd0);
    check("md_btn", 64'(mouse_buttons), 64'd0);
    check("md_x_held", 64'(mouse_x), 64'd6);
    check("md_y_held", 64'(mouse_y), 64'hFFFFFFFF);
    bus_wr(4'd3, 32'h100);
    bus_rd_chk("mz_rd_x", 4'd4, 32'd0);
    bus_rd_chk("mz_rd_wheel", 4'd6, 32'd0);

    // Test 4: keyboard watchdog timeout
    bus_wr(4'd0, 32'h1A1B1C05);
    bus_wr(4'd1, 32'h00201F1E);
    push_kbd(8'h05, 48'h201F1E1A1B1C);
    bus_wr(4'd3, 32'h1);
    c = cyc; f = fall_edge(c);
    wait_cyc(f - 1);
    check("t4_conn_before", 64'(keyboard_connected), 64'd1);
    @(negedge clk);
    check("t4_conn_after", 64'(keyboard_connected), 64'd0);
    check("t4_mods_cleared", 64'(keyboard_modifiers), 64'd0);
    check("t4_keys_cleared", 64'(keyboard_keycodes), 64'd0);
    // Commit on the exact timeout cycle keeps the keyboard connected
    push_kbd(8'h05, 48'h201F1E1A1B1C);
    bus_wr(4'd3, 32'h1);
    c = cyc; f = fall_edge(c);
    wait_cyc(f - 1);
    push_kbd(8'h05, 48'h201F1E1A1B1C);
    bus_wr_now(4'd3, 32'h1);
    check("t4_race_conn", 64'(keyboard_connected), 64'd1);
    @(negedge clk);
    check("t4_race_conn_hold", 64'(keyboard_connected), 64'd1);
    check("t4_race_mods", 64'(keyboard_modifiers), 64'h05);

    // Test 5: disconnect overrides commit, staging preserved
    bus_wr(4'd3, 32'h11);
    check("t5_conn", 64'(keyboard_connected), 64'd0);
    check("t5_keys", 64'(keyboard_keycodes), 64'd0);
    check("t5_mods", 64'(keyboard_modifiers), 64'd0);
    bus_rd_chk("t5_rd_ctrl", 4'd3, 32'd0);
    bus_rd_chk("t5_rd_kbd0", 4'd0, 32'h1A1B1C05);
    bus_rd_chk("t5_rd_kbd1", 4'd1, 32'h00201F1E);
    bus_rd_chk("t5_rd_unmapped", 4'd9, 32'd0);

    // Test 6: asynchronous reset between edges
    bus_wr(4'd3, 32'h3);
    check("t6_pre_pulse", 64'(kbd_update_o), 64'd1);
    check("t6_pre_conn", 64'(keyboard_connected), 64'd1);
    m_sel = 1'b1; m_rd = 1'b1; m_addr = 4'd0;
    #1;
    rst = 1'b1;
    #1;
    check("t6_kconn", 64'(keyboard_connected), 64'd0);
    check("t6_mconn", 64'(mouse_connected), 64'd0);
    check("t6_mods", 64'(keyboard_modifiers), 64'd0);
    check("t6_keys", 64'(keyboard_keycodes), 64'd0);
    check("t6_btn", 64'(mouse_buttons), 64'd0);
    check("t6_mx", 64'(mouse_x), 64'd0);
    check("t6_pulses", 64'({kbd_update_o, mouse_update_o}), 64'd0);
    check("t6_rd_kbd0", 64'(m_data_o), 64'd0);
    m_sel = 1'b0; m_rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check("kbd_queue_drained", 64'(kbd_q.size()), 64'd0);
    check("mouse_queue_drained", 64'(mouse_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
